spm_seq_ctrl: RTL and testbench

- Sequencer for the signed N×N serial-parallel multiplier (SPM) datapath.
- Takes an already-synchronized start level from the two-flop synchronizer, latches operands, and clears the SPM. It then streams the multiplier serially, LSB first with sign extension, for 2N cycles, deserializes the serial product and presents a 2N-bit signed result with a one-cycle done pulse.
- Sits between the board-level control/synchronizer and the SPM array.

---
 rtl/spm_pkg.sv | 14 +
 rtl/rise_det.sv | 22 ++
 rtl/spm_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_spm_seq_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared constants for the serial-parallel multiplier sequencer:
// default operand width, SPM latency and the sequencer state encoding.
package spm_pkg;

   localparam int N_DEF   = 8;
   localparam int LAT_DEF = 1;
   localparam int CNT_W   = $clog2(2 * N_DEF + LAT_DEF);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector for an already-synchronized level. The history flop
// resets to 1 so a level held high through reset release is not an edge.
module rise_det (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic level_i,
   output logic rise_o
);

   logic level_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         level_q <= 1'b1;
      end else begin
         level_q <= level_i;
      end
   end

   assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the signed NxN serial-parallel multiplier: latches operands,
// streams the multiplier LSB first and deserializes the 2N-bit product.
//
//   state | meaning
//   IDLE  | waiting for a rising edge on start_sync
//   LOAD  | operands latched, SPM cleared
//   RUN   | 2N+LAT cycles of serial multiplier out / product in
//   DONE  | product updated, done pulse high
module spm_seq_ctrl
   import spm_pkg::*;
#(
   parameter int N   = N_DEF,
   parameter int LAT = LAT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_sync,
   input  logic [N-1:0]     a_in,
   input  logic [N-1:0]     b_in,
   output logic             spm_clr,
   output logic             spm_en,
   output logic [N-1:0]     spm_y,
   output logic             spm_x,
   input  logic             spm_p,
   output logic [2*N-1:0]   product,
   output logic             busy,
   output logic             done
);

   localparam int RUN_CYC = 2 * N + LAT;
   localparam int CW      = $clog2(RUN_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(RUN_CYC - 1);
   localparam logic [CW-1:0] CNT_LAT  = CW'(LAT);

   logic             start_rise;
   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     y_q, y_d;
   logic [N-1:0]     x_sh_q, x_sh_d;
   logic [2*N-1:0]   prod_sh_q, prod_sh_d;
   logic [2*N-1:0]   product_q, product_d;
   logic             spm_clr_q, spm_clr_d;
   logic             spm_en_q, spm_en_d;
   logic             spm_x_q, spm_x_d;
   logic             busy_q;
   logic             done_q, done_d;

   rise_det u_rise_det (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .level_i (start_sync),
      .rise_o  (start_rise)
   );

   // Output registers are loaded with the value they must show in the
   // next state, so every output is a flop yet lines up with the state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      y_d       = y_q;
      x_sh_d    = x_sh_q;
      prod_sh_d = prod_sh_q;
      product_d = product_q;
      spm_clr_d = 1'b0;
      spm_en_d  = 1'b0;
      spm_x_d   = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_rise) begin
               state_d   = ST_LOAD;
               spm_clr_d = 1'b1;
            end
         end
         ST_LOAD: begin
            y_d      = a_in;
            x_sh_d   = b_in;
            cnt_d    = '0;
            state_d  = ST_RUN;
            spm_en_d = 1'b1;
            spm_x_d  = b_in[0];
         end
         ST_RUN: begin
            x_sh_d = {x_sh_q[N-1], x_sh_q[N-1:1]};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q >= CNT_LAT) begin
               prod_sh_d = {spm_p, prod_sh_q[2*N-1:1]};
            end
            if (cnt_q == CNT_LAST) begin
               state_d   = ST_DONE;
               product_d = prod_sh_d;
               done_d    = 1'b1;
            end else begin
               spm_en_d = 1'b1;
               spm_x_d  = x_sh_d[0];
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         y_q       <= '0;
         x_sh_q    <= '0;
         prod_sh_q <= '0;
         product_q <= '0;
         spm_clr_q <= 1'b0;
         spm_en_q  <= 1'b0;
         spm_x_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         y_q       <= y_d;
         x_sh_q    <= x_sh_d;
         prod_sh_q <= prod_sh_d;
         product_q <= product_d;
         spm_clr_q <= spm_clr_d;
         spm_en_q  <= spm_en_d;
         spm_x_q   <= spm_x_d;
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= done_d;
      end
   end

   assign spm_clr = spm_clr_q;
   assign spm_en  = spm_en_q;
   assign spm_y   = y_q;
   assign spm_x   = spm_x_q;
   assign product = product_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Testbench for spm_seq_ctrl with a behavioural SPM array model and an
// arithmetic reference for the expected product.
module tb_spm_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_sync = 1'b0;
   logic [7:0]  a_in = 8'd0;
   logic [7:0]  b_in = 8'd0;
   logic        spm_clr, spm_en, spm_x, busy, done;
   logic [7:0]  spm_y;
   logic        spm_p = 1'b0;
   logic [15:0] product;

   int npass = 0;
   int ntot  = 0;

   spm_seq_ctrl #(.N(8), .LAT(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_sync (start_sync),
      .a_in       (a_in),
      .b_in       (b_in),
      .spm_clr    (spm_clr),
      .spm_en     (spm_en),
      .spm_y      (spm_y),
      .spm_x      (spm_x),
      .spm_p      (spm_p),
      .product    (product),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // SPM array model: accumulates y * x_k * 2^k; bit k is final once term k
   // is added and appears on spm_p one cycle later.
   logic [15:0] acc = 16'd0;
   logic [15:0] acc_nxt;
   int          kk = 0;
   always @(posedge clk) begin
      if (spm_clr) begin
         acc = 16'd0;
         kk = 0;
         spm_p <= 1'b0;
      end else if (spm_en) begin
         acc_nxt = acc;
         if (spm_x && kk < 16) acc_nxt = acc + ({{8{spm_y[7]}}, spm_y} << kk);
         acc = acc_nxt;
         spm_p <= (kk < 16) ? acc_nxt[kk] : 1'b0;
         kk++;
      end
   end

   function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[15:0];
   endfunction

   // Runs one multiply (start low for a cycle, then high) and records what
   // the DUT did over 40 cycles after the edge-sample cycle.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit glitch,
                         output int latency, output int busy_cyc, output int done_cnt,
                         output logic [15:0] prod, output logic [15:0] xbits,
                         output int en_cyc, output int clr_at, output logic [7:0] y_seen,
                         output logic [15:0] prod_end);
      int xk;
      @(negedge clk);
      start_sync = 1'b0;
      a_in = a;
      b_in = b;
      @(negedge clk);
      start_sync = 1'b1;
      latency = -1; busy_cyc = 0; done_cnt = 0; en_cyc = 0; clr_at = -1;
      xk = 0; xbits = 16'd0; prod = 16'hxxxx; y_seen = 8'hxx;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (busy) busy_cyc++;
         if (spm_clr) clr_at = cyc;
         if (spm_en) begin
            if (xk < 16) xbits[xk] = spm_x;
            xk++;
            en_cyc++;
         end
         if (cyc == 3) y_seen = spm_y;
         if (done) begin
            done_cnt++;
            if (latency < 0) begin
               latency = cyc;
               prod = product;
            end
         end
         if (glitch) begin
            if (cyc == 3) begin a_in = ~a_in; b_in = ~b_in; end
            if (cyc == 5) start_sync = 1'b0;
            if (cyc == 8) start_sync = 1'b1;
         end
      end
      prod_end = product;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_sync = 1'b0;
      repeat (3) @(negedge clk);
      ntot++; if (product !== 16'd0) $display("FAIL reset_product got=%h exp=0000", product); else npass++;
      ntot++; if ({done, busy, spm_clr, spm_en, spm_x} !== 5'b0)
         $display("FAIL reset_ctrl got=%b exp=00000", {done, busy, spm_clr, spm_en, spm_x}); else npass++;
      ntot++; if (spm_y !== 8'd0) $display("FAIL reset_spm_y got=%h exp=00", spm_y); else npass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      ntot++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", busy); else npass++;
   endtask

   task automatic test_mult();
      logic [7:0]  da [5] = '{8'd3, 8'h80, 8'hFF, 8'd127, 8'd0};
      logic [7:0]  db [5] = '{8'd5, 8'h80, 8'd127, 8'h80, 8'hB3};
      logic [7:0]  a, b, y_seen;
      logic [15:0] exp, prod, xbits, prod_end;
      int lat, bc, dc, ec, ca;
      for (int i = 0; i < 29; i++) begin
         if (i < 5) begin a = da[i]; b = db[i]; end
         else begin a = 8'($urandom); b = 8'($urandom); end
         exp = ref_mul(a, b);
         run_op(a, b, 1'b0, lat, bc, dc, prod, xbits, ec, ca, y_seen, prod_end);
         ntot++; if (lat !== 19) $display("FAIL latency a=%h b=%h got=%0d exp=19", a, b, lat); else npass++;
         ntot++; if (prod !== exp) $display("FAIL product a=%h b=%h got=%h exp=%h", a, b, prod, exp); else npass++;
         ntot++; if (prod_end !== exp) $display("FAIL product_hold a=%h b=%h got=%h exp=%h", a, b, prod_end, exp); else npass++;
         ntot++; if (bc !== 19) $display("FAIL busy_cycles a=%h b=%h got=%0d exp=19", a, b, bc); else npass++;
         ntot++; if (dc !== 1) $display("FAIL done_count a=%h b=%h got=%0d exp=1", a, b, dc); else npass++;
         ntot++; if (xbits !== {{8{b[7]}}, b}) $display("FAIL spm_x_seq b=%h got=%h exp=%h", b, xbits, {{8{b[7]}}, b}); else npass++;
         ntot++; if (ec !== 17) $display("FAIL en_cycles got=%0d exp=17", ec); else npass++;
         ntot++; if (ca !== 1) $display("FAIL clr_cycle got=%0d exp=1", ca); else npass++;
         ntot++; if (y_seen !== a) $display("FAIL spm_y got=%h exp=%h", y_seen, a); else npass++;
      end
   endtask

   task automatic test_restart_ignored();
      logic [7:0]  y_seen;
      logic [15:0] prod, xbits, prod_end;
      int lat, bc, dc, ec, ca;
      run_op(8'd23, 8'hE9, 1'b1, lat, bc, dc, prod, xbits, ec, ca, y_seen, prod_end);
      ntot++; if (dc !== 1) $display("FAIL restart_done_count got=%0d exp=1", dc); else npass++;
      ntot++; if (prod !== ref_mul(8'd23, 8'hE9))
         $display("FAIL restart_product got=%h exp=%h", prod, ref_mul(8'd23, 8'hE9)); else npass++;
      ntot++; if (lat !== 19) $display("FAIL restart_latency got=%0d exp=19", lat); else npass++;
   endtask

   task automatic test_reset_mid();
      logic [7:0]  y_seen;
      logic [15:0] prod, xbits, prod_end;
      int lat, bc, dc, ec, ca, nd, nb;
      @(negedge clk);
      start_sync = 1'b0;
      a_in = 8'd55;
      b_in = 8'd66;
      @(negedge clk);
      start_sync = 1'b1;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ntot++; if (product !== 16'd0) $display("FAIL midreset_product got=%h exp=0000", product); else npass++;
      nd = 0; nb = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done) nd++;
         if (busy) nb++;
      end
      ntot++; if (nd !== 0) $display("FAIL midreset_no_done got=%0d exp=0", nd); else npass++;
      ntot++; if (nb !== 0) $display("FAIL midreset_idle got=%0d exp=0", nb); else npass++;
      run_op(8'hFE, 8'd3, 1'b0, lat, bc, dc, prod, xbits, ec, ca, y_seen, prod_end);
      ntot++; if (prod !== 16'hFFFA) $display("FAIL after_reset_product got=%h exp=fffa", prod); else npass++;
   endtask

   task automatic test_held_start();
      logic [7:0]  y_seen;
      logic [15:0] prod, xbits, prod_end;
      int lat, bc, dc, ec, ca, nb;
      @(negedge clk);
      start_sync = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nb = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (busy || done) nb++;
      end
      ntot++; if (nb !== 0) $display("FAIL held_start_no_op got=%0d exp=0", nb); else npass++;
      run_op(8'd7, 8'd9, 1'b0, lat, bc, dc, prod, xbits, ec, ca, y_seen, prod_end);
      ntot++; if (prod !== 16'd63) $display("FAIL held_then_edge_product got=%h exp=003f", prod); else npass++;
      ntot++; if (lat !== 19) $display("FAIL held_then_edge_latency got=%0d exp=19", lat); else npass++;
   endtask

   initial begin
      test_reset();
      test_mult();
      test_restart_ignored();
      test_reset_mid();
      test_held_start();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
